spatial_upsampler: RTL

//  2x2 nearest-neighbour spatial upsampler (un-pooling). Inverse of the 2x2 max-pool subsampler.

---
 rtl/upsamp_pkg.sv | 20 ++
 rtl/spatial_upsampler_line_buffer.sv | 24 ++
 rtl/spatial_upsampler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/upsamp_pkg.sv
// Shared types and config-word helpers for the 2x2 up/down-sampling blocks.
// config_bits packs {nPeriod, nData}, with nData in the low bits.
package upsamp_pkg;

   typedef enum logic [1:0] {IDLE, ROW_A, ROW_B} state_t;

   function automatic int len_config_bits(input int max_ndata, input int max_nperiod);
      return $clog2(max_ndata) + $clog2(max_nperiod);
   endfunction

   function automatic logic [31:0] get_ndata(input logic [31:0] cfg, input int nd_bits);
      return cfg & ((32'd1 << nd_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] get_nperiod(input logic [31:0] cfg, input int nd_bits,
                                               input int np_bits);
      return (cfg >> nd_bits) & ((32'd1 << np_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/spatial_upsampler_line_buffer.sv
// One-row pixel store: synchronous write, combinational read.
// Contents are not reset; every location is rewritten before it is replayed.
module line_buffer #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/spatial_upsampler.sv
// 2x2 nearest-neighbour upsampler: each input row is passed through with every pixel
// doubled (ROW_A) and then replayed doubled from the line buffer (ROW_B).
module spatial_upsampler
   import upsamp_pkg::*;
#(
   parameter  int WIDTH           = 16,
   parameter  int MAX_nData       = 32,
   parameter  int MAX_nPeriod     = 64,
   localparam int LEN_CONFIG_BITS = len_config_bits(MAX_nData, MAX_nPeriod)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LEN_CONFIG_BITS-1:0] config_bits,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       data_in_en,
   output logic                       data_in_ready,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_out_en,
   output logic                       busy,
   output logic                       done
);

   localparam int ND_W = $clog2(MAX_nData);
   localparam int NP_W = $clog2(MAX_nPeriod);

   state_t            state, state_nx;
   logic [ND_W-1:0]   n_data, col_cnt, cfg_nd;
   logic [NP_W-1:0]   n_period, row_cnt, cfg_np;
   logic [WIDTH-1:0]  hold, lb_rdata;
   logic              pend, rep;
   logic              start_ok, accept, col_last, row_last;

   assign cfg_nd = ND_W'(get_ndata(32'(config_bits), ND_W));
   assign cfg_np = NP_W'(get_nperiod(32'(config_bits), ND_W, NP_W));

   // busy stays high through the done cycle, so a start coincident with done is dropped
   assign start_ok      = start && (state == IDLE) && !busy && (cfg_nd != '0) && (cfg_np != '0);
   assign data_in_ready = (state == ROW_A) && !pend;
   assign accept        = data_in_en && data_in_ready;
   assign col_last      = (col_cnt == n_data - ND_W'(1));
   assign row_last      = (row_cnt == n_period - NP_W'(1));

   line_buffer #(.WIDTH(WIDTH), .DEPTH(MAX_nData)) u_line_buffer (
      .clk   (clk),
      .we    (accept),
      .waddr (col_cnt),
      .wdata (data_in),
      .raddr (col_cnt),
      .rdata (lb_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_ok) state_nx = ROW_A;
         ROW_A:   if (pend && col_last) state_nx = ROW_B;
         ROW_B:   if (rep && col_last) state_nx = row_last ? IDLE : ROW_A;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         n_data      <= '0;
         n_period    <= '0;
         col_cnt     <= '0;
         row_cnt     <= '0;
         hold        <= '0;
         pend        <= 1'b0;
         rep         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         data_out    <= '0;
         data_out_en <= 1'b0;
      end else begin
         data_out    <= '0;
         data_out_en <= 1'b0;
         done        <= 1'b0;
         if (done) busy <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  n_data   <= cfg_nd;
                  n_period <= cfg_np;
                  busy     <= 1'b1;
                  col_cnt  <= '0;
                  row_cnt  <= '0;
                  pend     <= 1'b0;
                  rep      <= 1'b0;
               end
            end
            ROW_A: begin
               if (pend) begin
                  data_out    <= hold;
                  data_out_en <= 1'b1;
                  pend        <= 1'b0;
                  col_cnt     <= col_last ? '0 : col_cnt + ND_W'(1);
               end else if (accept) begin
                  data_out    <= data_in;
                  data_out_en <= 1'b1;
                  hold        <= data_in;
                  pend        <= 1'b1;
               end
            end
            ROW_B: begin
               // rep selects first/second copy of the current buffered pixel
               data_out    <= lb_rdata;
               data_out_en <= 1'b1;
               rep         <= !rep;
               if (rep) begin
                  col_cnt <= col_last ? '0 : col_cnt + ND_W'(1);
                  if (col_last) begin
                     if (row_last) begin
                        done    <= 1'b1;
                        row_cnt <= '0;
                     end else begin
                        row_cnt <= row_cnt + NP_W'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
